// File: rtl/move_sequencer_pkg.sv
// move_sequencer_pkg: direction codes, sequencer states and key priority encoder
package move_sequencer_pkg;
    localparam logic [3:0] DIR_U = 4'b0001;
    localparam logic [3:0] DIR_D = 4'b0010;
    localparam logic [3:0] DIR_L = 4'b0100;
    localparam logic [3:0] DIR_R = 4'b1000;
    typedef enum logic [1:0] {S_IDLE, S_MOVE, S_STORE} state_t;
    // Simultaneous presses collapse to one command, U > D > L > R
    function automatic logic [3:0] prio_dir(input logic [3:0] p);
        return p[0] ? DIR_U : p[1] ? DIR_D : p[2] ? DIR_L : p[3] ? DIR_R : 4'b0000;
    endfunction
endpackage

// File: rtl/move_sequencer_if.sv
// move_sequencer_if: key inputs, datapath handshake and status outputs of the sequencer
interface move_sequencer_if #(
    parameter int FIFO_DEPTH = 4,
    parameter int STEP_W = 10
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    logic U, D, L, R, move_able;
    logic [3:0] code;
    logic move, store, busy, drop;
    logic [CW-1:0] pending;
    logic [STEP_W-1:0] step_cnt;
    modport master(
        input U, D, L, R, move_able,
        output code, move, store, busy, drop, pending, step_cnt
    );
    modport slave(
        output U, D, L, R, move_able,
        input code, move, store, busy, drop, pending, step_cnt
    );
endinterface

// File: rtl/move_sequencer_dir_fifo.sv
// dir_fifo: pending-move queue of one-hot directions; push/pop arrive pre-qualified
module dir_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [3:0]               din,
    output logic [3:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [3:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    assign dout = mem[rp];
    assign full = count == (AW + 1)'(DEPTH);
    assign empty = count == '0;
    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge clr)
        if (clr) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    // Storage needs no reset; occupancy decides what is valid
    always_ff @(posedge clk)
        if (push) mem[wp] <= din;
endmodule

// File: rtl/move_sequencer.sv
// move_sequencer: turns key presses into queued single-step move/store commands
module move_sequencer
    import move_sequencer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int STEP_W = 10,
    parameter int REPEAT_CYC = 25_000_000
) (
    input logic clk,
    input logic clr,
    move_sequencer_if.master bus
);
    localparam int TW = REPEAT_CYC > 1 ? $clog2(REPEAT_CYC) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(REPEAT_CYC > 0 ? REPEAT_CYC - 1 : 0);
    logic [3:0] keys, prev, press, cmd, dout;
    logic [TW-1:0] timer;
    logic single, changed, rep, pop, push, full, empty;
    state_t state;
    assign keys = {bus.R, bus.L, bus.D, bus.U};
    assign single = $onehot(keys);
    assign changed = keys != prev;
    assign rep = (REPEAT_CYC > 0) && single && !changed && timer == T_LAST;
    assign press = (keys & ~prev) | (rep ? keys : 4'b0000);
    assign cmd = prio_dir(press);
    assign pop = state == S_IDLE && !empty;
    assign push = |press && (!full || pop);
    assign bus.busy = state != S_IDLE || !empty;
    dir_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .clr(clr), .push(push), .pop(pop), .din(cmd),
        .dout(dout), .full(full), .empty(empty), .count(bus.pending)
    );
    // Key history and auto-repeat timer; the timer only runs while one key is held steady
    always_ff @(posedge clk or posedge clr)
        if (clr) begin
            prev <= '0;
            timer <= '0;
        end else begin
            prev <= keys;
            timer <= (single && !changed && !rep) ? timer + 1'b1 : '0;
        end
    // Command FSM: pop, evaluate with move, commit with store; all outputs registered
    always_ff @(posedge clk or posedge clr)
        if (clr) begin
            state <= S_IDLE;
            bus.code <= '0;
            bus.move <= 1'b0;
            bus.store <= 1'b0;
            bus.drop <= 1'b0;
            bus.step_cnt <= '0;
        end else begin
            bus.drop <= |press && full && !pop;
            bus.move <= 1'b0;
            bus.store <= 1'b0;
            case (state)
                S_IDLE:
                    if (!empty) begin
                        bus.code <= dout;
                        bus.move <= 1'b1;
                        state <= S_MOVE;
                    end
                S_MOVE:
                    if (bus.move_able) begin
                        bus.store <= 1'b1;
                        if (!(&bus.step_cnt)) bus.step_cnt <= bus.step_cnt + 1'b1;
                        state <= S_STORE;
                    end else state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
endmodule

// File: tb/tb_move_sequencer.sv
// tb_move_sequencer: randomized and directed checks against a timeline model of the sequencer
module tb_move_sequencer;
    logic clk = 1'b0;
    logic clr = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;
    move_sequencer_if #(.FIFO_DEPTH(4), .STEP_W(10)) m_if ();
    move_sequencer_if #(.FIFO_DEPTH(4), .STEP_W(2)) s_if ();
    move_sequencer #(.FIFO_DEPTH(4), .STEP_W(10), .REPEAT_CYC(8)) dut (
        .clk(clk), .clr(clr), .bus(m_if.master)
    );
    move_sequencer #(.FIFO_DEPTH(4), .STEP_W(2), .REPEAT_CYC(8)) dut_sat (
        .clk(clk), .clr(clr), .bus(s_if.master)
    );
    assign s_if.U = m_if.U;
    assign s_if.D = m_if.D;
    assign s_if.L = m_if.L;
    assign s_if.R = m_if.R;
    assign s_if.move_able = m_if.move_able;
    always #5 clk = ~clk;

    // Reference model: queue of directions plus the edge at which the issuer is next free
    logic [3:0] m_prev, m_code;
    logic m_move, m_store, m_drop;
    int m_held, m_step, m_free, m_n;
    logic [3:0] q[$];

    task automatic model_reset();
        m_prev = 0; m_code = 0; m_move = 0; m_store = 0; m_drop = 0;
        m_held = 0; m_step = 0; m_free = 0; m_n = 0;
        q.delete();
    endtask

    task automatic model_edge(input logic [3:0] k, input logic ma);
        int held;
        logic rep, pop, st;
        logic [3:0] pv, pick;
        held = (k == m_prev) ? m_held + 1 : 0;
        rep = $countones(k) == 1 && held > 0 && held % 8 == 0;
        pv = (k & ~m_prev) | (rep ? k : 4'b0);
        pick = 0;
        for (int i = 3; i >= 0; i--) if (pv[i]) pick = 4'b0001 << i;
        st = 0;
        if (m_move) begin
            if (ma) begin
                st = 1;
                m_step++;
                m_free = m_n + 2;
            end else m_free = m_n + 1;
        end
        pop = !m_move && m_n >= m_free && q.size() > 0;
        m_store = st;
        m_move = pop;
        if (pop) m_code = q.pop_front();
        m_drop = 0;
        if (pv != 0) begin
            if (q.size() < 4) q.push_back(pick);
            else m_drop = 1;
        end
        m_prev = k;
        m_held = held;
        m_n++;
    endtask

    function automatic logic [20:0] exp_vec();
        int s;
        s = m_step > 1023 ? 1023 : m_step;
        return {m_code, m_move, m_store, m_drop, (m_move || m_store || q.size() != 0),
                3'(q.size()), 10'(s)};
    endfunction

    function automatic logic [20:0] dut_vec();
        return {m_if.code, m_if.move, m_if.store, m_if.drop, m_if.busy, m_if.pending, m_if.step_cnt};
    endfunction

    function automatic logic [1:0] exp_sat();
        return m_step > 3 ? 2'd3 : 2'(m_step);
    endfunction

    task automatic step(input logic [3:0] k, input logic ma);
        {m_if.R, m_if.L, m_if.D, m_if.U} = k;
        m_if.move_able = ma;
        @(posedge clk);
        model_edge(k, ma);
        #1;
    endtask

    task automatic do_reset();
        {m_if.R, m_if.L, m_if.D, m_if.U} = 4'b0;
        m_if.move_able = 1'b0;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        {m_if.R, m_if.L, m_if.D, m_if.U} = 4'b0;
        m_if.move_able = 1'b1;
        clr = 1'b1;
        #1;
        n_cmp++;
        if (dut_vec() !== 21'd0 || s_if.step_cnt !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_async: got %h expected 0", dut_vec());
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (dut_vec() !== 21'd0) begin
            n_bad++;
            $display("FAIL reset_held: got %h expected 0", dut_vec());
        end
        clr = 1'b0;
        model_reset();
    endtask

    task automatic test_single_press();
        do_reset();
        for (int i = 0; i < 5; i++) step(4'b0000, 1'b1);
        step(4'b0001, 1'b1);
        n_cmp++;
        if (m_if.pending !== 3'd1 || m_if.move !== 1'b0 || dut_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL single_enqueue: got %h expected %h", dut_vec(), exp_vec());
        end
        step(4'b0000, 1'b1);
        n_cmp++;
        if (m_if.move !== 1'b1 || m_if.code !== 4'b0001 || m_if.store !== 1'b0) begin
            n_bad++;
            $display("FAIL single_move: got move=%b code=%b expected move=1 code=0001", m_if.move, m_if.code);
        end
        step(4'b0000, 1'b1);
        n_cmp++;
        if (m_if.store !== 1'b1 || m_if.move !== 1'b0 || m_if.step_cnt !== 10'd1 || dut_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL single_store: got %h expected %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_simultaneous();
        int moves, maxp, bad;
        moves = 0; maxp = 0; bad = 0;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            step(i < 3 ? 4'b1001 : 4'b0000, 1'b1);
            if (dut_vec() !== exp_vec()) bad++;
            if (m_if.move === 1'b1) moves++;
            if (int'(m_if.pending) > maxp) maxp = int'(m_if.pending);
        end
        n_cmp++;
        if (moves != 1 || maxp != 1 || m_if.code !== 4'b0001 || bad != 0) begin
            n_bad++;
            $display("FAIL simultaneous: got moves=%0d peak=%0d code=%b diffs=%0d expected 1 1 0001 0", moves, maxp, m_if.code, bad);
        end
    endtask

    task automatic test_overflow();
        int drops, stores, bad;
        drops = 0; stores = 0; bad = 0;
        do_reset();
        for (int i = 0; i < 24; i++) begin
            step(i >= 12 ? 4'b0000 : (i % 2 == 0 ? 4'b0001 : 4'b0010), 1'b0);
            if (dut_vec() !== exp_vec()) bad++;
            if (m_if.drop === 1'b1) drops++;
            if (m_if.store === 1'b1) stores++;
        end
        n_cmp++;
        if (drops != 2 || stores != 0 || m_if.step_cnt !== 10'd0 || bad != 0) begin
            n_bad++;
            $display("FAIL overflow: got drops=%0d stores=%0d steps=%0d diffs=%0d expected 2 0 0 0", drops, stores, m_if.step_cnt, bad);
        end
    endtask

    task automatic test_auto_repeat();
        int moves, wrong, bad;
        moves = 0; wrong = 0; bad = 0;
        do_reset();
        for (int i = 0; i < 32; i++) begin
            step(i < 20 ? 4'b0100 : 4'b0000, 1'b1);
            if (dut_vec() !== exp_vec()) bad++;
            if (m_if.move === 1'b1) begin
                moves++;
                if (m_if.code !== 4'b0100) wrong++;
            end
        end
        n_cmp++;
        if (moves != 3 || wrong != 0 || m_if.step_cnt !== 10'd3 || bad != 0) begin
            n_bad++;
            $display("FAIL auto_repeat: got moves=%0d wrongcode=%0d steps=%0d diffs=%0d expected 3 0 3 0", moves, wrong, m_if.step_cnt, bad);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        step(4'b0001, 1'b0);
        step(4'b0010, 1'b0);
        step(4'b0100, 1'b0);
        step(4'b1000, 1'b0);
        n_cmp++;
        if (m_if.move !== 1'b1 || m_if.pending !== 3'd2 || dut_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL midreset_setup: got %h expected %h", dut_vec(), exp_vec());
        end
        {m_if.R, m_if.L, m_if.D, m_if.U} = 4'b0;
        m_if.move_able = 1'b1;
        clr = 1'b1;
        #1;
        n_cmp++;
        if (dut_vec() !== 21'd0 || s_if.step_cnt !== 2'd0) begin
            n_bad++;
            $display("FAIL midreset_clear: got %h expected 0", dut_vec());
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (dut_vec() !== 21'd0) begin
            n_bad++;
            $display("FAIL midreset_nostore: got %h expected 0", dut_vec());
        end
        clr = 1'b0;
        model_reset();
        step(4'b0000, 1'b1);
        step(4'b0001, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        n_cmp++;
        if (m_if.store !== 1'b1 || m_if.step_cnt !== 10'd1 || dut_vec() !== exp_vec()) begin
            n_bad++;
            $display("FAIL midreset_after: got %h expected %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_saturation();
        logic [1:0] tbl [5];
        tbl = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(4'b0010, 1'b1);
            step(4'b0000, 1'b1);
            step(4'b0000, 1'b1);
            n_cmp++;
            if (s_if.step_cnt !== tbl[i] || s_if.store !== 1'b1 || exp_sat() !== tbl[i] || m_if.step_cnt !== 10'(i + 1)) begin
                n_bad++;
                $display("FAIL saturation_%0d: got small=%0d wide=%0d expected %0d %0d", i, s_if.step_cnt, m_if.step_cnt, tbl[i], i + 1);
            end
            step(4'b0000, 1'b1);
        end
    endtask

    task automatic test_random();
        logic [3:0] k;
        k = 0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) k = 4'($urandom);
            step(k, 1'($urandom));
            n_cmp++;
            if (dut_vec() !== exp_vec() || s_if.step_cnt !== exp_sat()) begin
                n_bad++;
                $display("FAIL random_c%0d: got %h/%0d expected %h/%0d", i, dut_vec(), s_if.step_cnt, exp_vec(), exp_sat());
            end
        end
    endtask

    initial begin
        {m_if.R, m_if.L, m_if.D, m_if.U} = 4'b0;
        m_if.move_able = 1'b0;
        test_reset();
        test_single_press();
        test_simultaneous();
        test_overflow();
        test_auto_repeat();
        test_mid_reset();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
